// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: x/y counters plus registered active, sync and frame strobes.
// Optional frame counter is built only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       next_frame,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] x_p0;
    logic [9:0] y_p0;
    logic       x_wrap;
    logic       next_frame_p0;

    // Stage 0: next-state counters; all registered flags decode these so they line up with x,y.
    always_comb begin
        x_wrap = (x == H_LAST);
        x_p0   = x_wrap ? 10'd0 : x + 10'd1;
        y_p0   = y;
        if (x_wrap) begin
            y_p0 = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
        next_frame_p0 = (x_p0 == 10'd0) && (y_p0 == V_VIS);
    end

    // Stage 1: registered raster position and decoded timing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= 10'd0;
            y          <= 10'd0;
            active     <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            next_frame <= 1'b0;
        end else begin
            x          <= x_p0;
            y          <= y_p0;
            active     <= (x_p0 < H_VIS) && (y_p0 < V_VIS);
            hsync      <= !((x_p0 >= HS_START) && (x_p0 < HS_END));
            vsync      <= !((y_p0 >= VS_START) && (y_p0 < VS_END));
            next_frame <= next_frame_p0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= 8'd0;
        end else if (next_frame_p0) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`else
    assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance and a 12x7 instance checked every cycle against
// a position model derived from cycles elapsed since reset release.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       nf;
        logic [7:0] fc;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_d = 1'b1;
    logic       rst_s = 1'b1;

    logic [9:0] x_d, y_d, x_s, y_s;
    logic       act_d, nf_d, hs_d, vs_d, act_s, nf_s, hs_s, vs_s;
    logic [7:0] fc_d, fc_s;

    longint n_d, n_s;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst_d), .x(x_d), .y(y_d), .active(act_d), .next_frame(nf_d),
        .hsync(hs_d), .vsync(vs_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_sml (
        .clk(clk), .rst(rst_s), .x(x_s), .y(y_s), .active(act_s), .next_frame(nf_s),
        .hsync(hs_s), .vsync(vs_s), .frame_count(fc_s)
    );

    // Clock edges seen since the last reset release.
    always @(posedge clk or posedge rst_d) begin
        if (rst_d) n_d <= 0;
        else       n_d <= n_d + 1;
    end
    always @(posedge clk or posedge rst_s) begin
        if (rst_s) n_s <= 0;
        else       n_s <= n_s + 1;
    end

    // Raster position follows directly from elapsed cycles; flags follow from the position.
    function automatic outs_t model(longint n, int ha, int hf, int hs, int hb,
                                    int va, int vf, int vs, int vb);
        outs_t r;
        longint ht, vt, pos, xx, yy, first_nf;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        r = '0;
        r.hsync = 1'b1;
        r.vsync = 1'b1;
        if (n == 0) return r;
        pos = n % (ht * vt);
        xx = pos % ht;
        yy = pos / ht;
        r.x = 10'(xx);
        r.y = 10'(yy);
        r.active = (xx < ha) && (yy < va);
        r.hsync = !((xx >= ha + hf) && (xx < ha + hf + hs));
        r.vsync = !((yy >= va + vf) && (yy < va + vf + vs));
        r.nf = (xx == 0) && (yy == va);
        first_nf = longint'(va) * ht;
`ifdef VGA_FRAME_COUNT_EN
        r.fc = (n >= first_nf) ? 8'(((n - first_nf) / (ht * vt) + 1) % 256) : 8'd0;
`else
        r.fc = (first_nf < 0) ? 8'd1 : 8'd0;
`endif
        return r;
    endfunction

    function automatic outs_t exp_d();
        return model(n_d, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic outs_t exp_s();
        return model(n_s, 8, 1, 2, 1, 4, 1, 1, 1);
    endfunction
    function automatic outs_t obs_d();
        return {x_d, y_d, act_d, hs_d, vs_d, nf_d, fc_d};
    endfunction
    function automatic outs_t obs_s();
        return {x_s, y_s, act_s, hs_s, vs_s, nf_s, fc_s};
    endfunction

    task automatic test_reset();
        outs_t rv;
        rv = '0;
        rv.hsync = 1'b1;
        rv.vsync = 1'b1;
        rst_d = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (obs_d() !== rv) begin
                mismatched++;
                $display("FAIL reset_def got %h required %h", obs_d(), rv);
            end
            compared++;
            if (obs_s() !== rv) begin
                mismatched++;
                $display("FAIL reset_sml got %h required %h", obs_s(), rv);
            end
        end
        rst_d = 1'b0;
        rst_s = 1'b0;
    endtask

    task automatic test_release();
        @(posedge clk);
        #1;
        compared++;
        if ({x_d, y_d, act_d} !== {10'd1, 10'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL release_first x=%0d y=%0d active=%0b required x=1 y=0 active=1", x_d, y_d, act_d);
        end
    endtask

    task automatic test_default_lines();
        outs_t o, e;
        int hs_low = 0, act_cnt = 0, hs_first = -1, hs_last = -1;
        for (int i = 0; i < 2 * 800 + 20; i++) begin
            @(negedge clk);
            o = obs_d();
            e = exp_d();
            compared++;
            if (o !== e) begin
                mismatched++;
                if (mismatched < 20) $display("FAIL def_raster n=%0d got %h required %h", n_d, o, e);
            end
            if (y_d == 10'd1) begin
                if (!hs_d) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(x_d);
                    hs_last = int'(x_d);
                end
                if (act_d) act_cnt++;
            end
        end
        compared++;
        if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
            mismatched++;
            $display("FAIL def_hsync_window low=%0d x=%0d..%0d required 96 x=656..751", hs_low, hs_first, hs_last);
        end
        compared++;
        if (act_cnt != 640) begin
            mismatched++;
            $display("FAIL def_active_count got %0d required 640", act_cnt);
        end
    endtask

    task automatic test_small_frames();
        outs_t o, e;
        int vs_low = 0, pulses = 0;
        longint last_nf = -1, gap = 0;
        logic [19:0] nf_pos = '1;
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 3 * 84; i++) begin
            @(negedge clk);
            o = obs_s();
            e = exp_s();
            compared++;
            if (o !== e) begin
                mismatched++;
                if (mismatched < 20) $display("FAIL sml_raster n=%0d got %h required %h", n_s, o, e);
            end
            if (!vs_s) vs_low++;
            if (nf_s) begin
                pulses++;
                if (last_nf >= 0) gap = n_s - last_nf;
                last_nf = n_s;
                nf_pos = {x_s, y_s};
            end
        end
        compared++;
        if (vs_low != 36) begin
            mismatched++;
            $display("FAIL sml_vsync_cycles got %0d required 36", vs_low);
        end
        compared++;
        if (pulses != 3 || gap != 84 || nf_pos !== {10'd0, 10'd4}) begin
            mismatched++;
            $display("FAIL sml_next_frame pulses=%0d gap=%0d pos=%h required 3 84 %h", pulses, gap, nf_pos, {10'd0, 10'd4});
        end
    endtask

    task automatic test_random_reset();
        outs_t o, e, rv;
        rv = '0;
        rv.hsync = 1'b1;
        rv.vsync = 1'b1;
        for (int k = 0; k < 10; k++) begin
            int run, hold, dly;
            run = int'($urandom_range(150, 1));
            hold = int'($urandom_range(4, 1));
            dly = int'($urandom_range(3, 1));
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                o = obs_s();
                e = exp_s();
                compared++;
                if (o !== e) begin
                    mismatched++;
                    if (mismatched < 20) $display("FAIL rnd_raster n=%0d got %h required %h", n_s, o, e);
                end
            end
            @(posedge clk);
            #(dly);
            rst_s = 1'b1;
            #1;
            compared++;
            if (obs_s() !== rv) begin
                mismatched++;
                $display("FAIL rnd_async_reset got %h required %h", obs_s(), rv);
            end
            for (int i = 0; i < hold; i++) @(negedge clk);
            rst_s = 1'b0;
        end
    endtask

    task automatic test_frame_count();
        outs_t o, e;
        longint target;
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        target = 48 + 256 * 84 + 1;
        while (n_s < target) begin
            @(negedge clk);
            o = obs_s();
            e = exp_s();
            compared++;
            if (o !== e) begin
                mismatched++;
                if (mismatched < 20) $display("FAIL fc_raster n=%0d got %h required %h", n_s, o, e);
            end
        end
        compared++;
`ifdef VGA_FRAME_COUNT_EN
        if (fc_s !== 8'd1) begin
            mismatched++;
            $display("FAIL fc_after_257 got %0d required 1", fc_s);
        end
`else
        if (fc_s !== 8'd0 || fc_d !== 8'd0) begin
            mismatched++;
            $display("FAIL fc_tied_zero got %0d/%0d required 0", fc_s, fc_d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_release();
        test_default_lines();
        test_small_frames();
        test_random_reset();
        test_frame_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout compared=%0d required completion", compared);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front-porch clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync-pulse clocks.
REQ-004 Parameter H_BACK, 48, horizontal back-porch clocks.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, V_SYNC, 2, V_BACK, 33: vertical front porch, sync and back porch, in lines.
REQ-007 clk  input  1  pixel clock; single clock domain.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-010 y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-011 active  output  1  high while x<H_ACTIVE and y<V_ACTIVE.
REQ-012 next_frame  output  1  one-cycle pulse marking the start of vertical blanking.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 frame_count  output  8  frame counter; see Configuration.

Function
REQ-016 H_TOTAL=H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525); all count compares are unsigned, 10-bit.
REQ-017 x increments by 1 every clk; x==H_TOTAL-1 wraps to 0 on the next clk.
REQ-018 y increments only on the clk where x wraps; y==V_TOTAL-1 with x wrap -> y=0 (frame wrap, both counters 0 together).
REQ-019 active, hsync, vsync and next_frame are registered; each is computed from the next-state counter values so it is cycle-aligned with the x,y it describes (zero relative latency).
REQ-020 hsync=0 iff H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751); 1 otherwise.
REQ-021 vsync=0 iff V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491), for every x on those lines.
REQ-022 next_frame=1 for exactly the one cycle where x==0 and y==V_ACTIVE (480,0); 0 otherwise; exactly one pulse per frame.
REQ-023 active is 0 throughout all horizontal and vertical blanking, including line 479 pixels 640..799.
REQ-024 No input affects counting; there are no stalls or enables; counting is free-running.

Reset
REQ-025 While rst=1: x=0, y=0, active=0, hsync=1, vsync=1, next_frame=0, frame_count=0.
REQ-026 Reset takes effect immediately (asynchronous); assertion mid-line or mid-frame abandons the frame with no partial pulse emitted.
REQ-027 First clk edge after rst release: x=1, y=0, active=1; pixel (0,0) of the first frame after reset is reported inactive; all later frames are complete.

Configuration
REQ-028 Macro VGA_FRAME_COUNT_EN defined: frame_count increments by 1 (mod 256) on the same clk edge that asserts next_frame; it wraps 255->0.
REQ-029 Macro VGA_FRAME_COUNT_EN undefined: frame_count is tied to 0 and no counter register is built; all other behaviour is identical.

Verification
REQ-030 Release reset, run 800*525 clks -> x,y step through every (x,y) once, ending with wrap to (0,0) and y increment only on x wrap.
REQ-031 Sample line y=100 -> hsync=0 for exactly 96 clks, x=656..751; active=1 for x=0..639 only.
REQ-032 Run 3 frames -> vsync=0 for exactly 2*800 clks per frame (y=490,491); next_frame pulses once per frame at (0,480), 420000 clks apart.
REQ-033 Assert rst at x=300,y=200 for 3 clks -> outputs take reset values the same cycle; after release x=1,y=0; no next_frame until y reaches 480.
REQ-034 With VGA_FRAME_COUNT_EN, run 257 frames -> frame_count wraps 255->0 and equals 1 after frame 257; without the macro, frame_count stays 0 throughout.
REQ-035 Override parameters to H 8/1/2/1, V 4/1/1/1 -> 12x7 raster; hsync low at x=9..10, vsync low on y=5, next_frame at (0,4).
